// File: rtl/uart_tx_fifo_module.sv
// uart_tx_fifo_module
// Transmit-side byte serialiser: pops bytes from a non-showahead TX FIFO and
// shifts them out LSB-first as asynchronous frames on TX_Pin_Out.
// Default build sends 8N1 frames (10 bits).
// Optional feature macro: UART_TX_PARITY_EN -- when defined, an even-parity
// bit is inserted between the last data bit and the stop bit (11-bit frame).
// Bit period is BAUD_DIV clock cycles (legal range 2..65535).

module uart_tx_fifo_module #(
    parameter int BAUD_DIV = 434
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Empty_Sig,
    input  logic [7:0] FIFO_Read_Data,
    output logic       Read_Req_Sig,
    output logic       TX_Pin_Out,
    output logic       TX_Busy_Sig
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LATCH,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Last count value of a bit period; the counter restarts at zero on every bit entry.
    localparam logic [15:0] BIT_END = 16'(BAUD_DIV - 1);

    state_t      state_reg;
    logic [15:0] baud_cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        req_reg;
    logic        tx_reg;
    logic        busy_reg;

    logic        bit_done;

    assign bit_done     = (baud_cnt_reg == BIT_END);
    assign Read_Req_Sig = req_reg;
    assign TX_Pin_Out   = tx_reg;
    assign TX_Busy_Sig  = busy_reg;

    // Frame sequencer: all outputs are registered and updated alongside the state.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            req_reg      <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            // The read request is a single-cycle pulse; only IDLE raises it.
            req_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!Empty_Sig) begin
                        state_reg <= REQ;
                        req_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                REQ: begin
                    state_reg <= LATCH;
                end
                LATCH: begin
                    // Non-showahead FIFO: q is valid the cycle after the request.
                    shift_reg    <= FIFO_Read_Data;
                    state_reg    <= START;
                    tx_reg       <= 1'b0;
                    baud_cnt_reg <= '0;
                end
                START: begin
                    if (bit_done) begin
                        state_reg    <= DATA;
                        tx_reg       <= shift_reg[0];
                        bit_idx_reg  <= '0;
                        baud_cnt_reg <= '0;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_reg <= PARITY;
                            tx_reg    <= ^shift_reg;
`else
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[bit_idx_reg + 3'd1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state_reg    <= STOP;
                        tx_reg       <= 1'b1;
                        baud_cnt_reg <= '0;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        state_reg    <= IDLE;
                        busy_reg     <= 1'b0;
                        baud_cnt_reg <= '0;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo_module.md
# uart_tx_fifo_module

Byte-serialiser on the transmit side of the UART interface. Pops bytes from the TX FIFO whenever it is non-empty and shifts them out LSB-first as asynchronous 8N1 frames on the TX pin. It is the reader of the FIFO that the interface controller writes; together with the RX path it closes the loopback.

## Interface

**Parameters**
- BAUD_DIV, default 434: CLK cycles per bit (50 MHz / 115200). Legal range 2..65535.

**Ports**
- CLK, input, 1: system clock, rising edge.
- RSTn, input, 1: reset, asynchronous, active-low.
- Empty_Sig, input, 1: TX FIFO empty flag.
- FIFO_Read_Data, input, 8: TX FIFO q output. Non-showahead: valid the cycle after the read request.
- Read_Req_Sig, output, 1: FIFO read request, one-cycle pulse, registered.
- TX_Pin_Out, output, 1: serial line, registered, idle high.
- TX_Busy_Sig, output, 1: high from the read request to the end of the stop bit.

## Operation

**State machine states:** IDLE, REQ, LATCH, START, DATA, [PARITY], STOP.
- IDLE: TX_Pin_Out = 1. If Empty_Sig = 0, go to REQ. Empty_Sig is sampled only in IDLE.
- REQ: Read_Req_Sig = 1 for this cycle only, then go to LATCH.
- LATCH: Read_Req_Sig = 0. Capture FIFO_Read_Data into the shift register at the end of this cycle, then go to START.
- START: TX_Pin_Out = 0 for BAUD_DIV cycles.
- DATA: 8 bits, shift register bit 0 first. Each bit is held BAUD_DIV cycles. A 3-bit index goes 0..7, then the FSM exits to PARITY or STOP.
- PARITY: exists only when the configuration macro is defined. See Configuration.
- STOP: TX_Pin_Out = 1 for BAUD_DIV cycles, then go to IDLE.

**Baud counter**
- 16-bit counter, cleared on every bit entry.
- The bit ends when the counter reaches BAUD_DIV-1.

**Data path**
- The shift register is loaded only in LATCH.
- FIFO_Read_Data is ignored at all other times.

**Boundary conditions**
- FIFO empty: the block sits in IDLE with no request and the line high.
- FIFO becomes non-empty mid-frame: ignored until IDLE is re-entered.
- Back-to-back bytes: IDLE, REQ and LATCH insert 3 extra line-high cycles after each stop bit. No bytes are lost and no duplicate reads occur.
- Exactly one Read_Req_Sig pulse is issued per frame transmitted.
- Reset mid-frame: all outputs return to reset values immediately and the partial byte is dropped. No request is issued until Empty_Sig = 0 is seen after reset.

**Reset values**
- State = IDLE.
- Read_Req_Sig = 0.
- TX_Pin_Out = 1.
- TX_Busy_Sig = 0.
- Counters and shift register = 0.

## Timing

- Read_Req_Sig is high in cycle N, where N is the cycle after IDLE sees Empty_Sig = 0.
- Data is latched at the end of cycle N+1.
- The start bit's falling edge on TX_Pin_Out appears in cycle N+2.
- The frame occupies 10·BAUD_DIV cycles (11·BAUD_DIV with parity), from cycle N+2 to the end of the stop bit.
- TX_Busy_Sig is high from cycle N through the last stop-bit cycle, and low in the following IDLE cycle.
- Back-to-back period is 10·BAUD_DIV + 3 cycles (11·BAUD_DIV + 3 with parity).
- All outputs are glitch-free register outputs.

## Configuration

- UART_TX_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for BAUD_DIV cycles.
  - The frame is 11 bits.
- UART_TX_PARITY_EN undefined:
  - There is no PARITY state.
  - The frame is 8N1 (10 bits).
  - No parity logic is synthesised.

## Test plan

All scenarios use BAUD_DIV = 4.

- **Reset idle:** hold RSTn = 0, then release with Empty_Sig = 1 for 100 cycles -> TX_Pin_Out = 1, Read_Req_Sig = 0, TX_Busy_Sig = 0 throughout.
- **Single byte:** FIFO holds 8'hA5 -> one Read_Req_Sig pulse, 1 cycle wide; start bit 2 cycles later; line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; TX_Busy_Sig falls after 40 frame cycles.
- **Back-to-back:** FIFO holds 8'h00, 8'hFF, 8'h55 -> exactly 3 pulses; frames 43 cycles apart; decoded bytes match in order.
- **Empty mid-frame:** Empty_Sig toggles during DATA -> no extra Read_Req_Sig; the next request comes only after IDLE.
- **Reset mid-frame:** assert RSTn during DATA bit 3 -> TX_Pin_Out = 1 and TX_Busy_Sig = 0 within the same cycle; after release, the next byte transmits cleanly.
- **Parity build (UART_TX_PARITY_EN):** send 8'h07 -> parity bit = 1, frame 44 cycles; send 8'h03 -> parity bit = 0.
